// File: rtl/fir_transposed_ntap.sv
// N-tap transposed-form FIR with runtime-loadable coefficients and valid-qualified streaming.
// Latency: 1 cycle from in_valid to out_valid; y holds between results.
// No backpressure: one result per accepted sample. Define FIR_SAT_EN for round+saturate output.
module fir_transposed_ntap #(
    parameter int TAPS   = 8,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        x,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_data,
    output logic                     out_valid,
    output logic [OUT_W-1:0]         y,
    output logic                     sat
);

    localparam int AW    = $clog2(TAPS);
    localparam int ACC_W = DATA_W + COEF_W + AW;

    // h_q[k] is tap k; z_q[j] holds the partial sum z[j+1] of the transposed delay line
    logic [COEF_W-1:0] h_q [TAPS];
    logic [ACC_W-1:0]  z_q [TAPS-1];
    logic [ACC_W-1:0]  z_d [TAPS-1];
    logic [ACC_W-1:0]  prod [TAPS];
    logic [ACC_W-1:0]  acc;
    logic [OUT_W-1:0]  y_q, y_d;
    logic              out_valid_q;

    // Full-precision products: operands sign-extended to ACC_W so the low ACC_W bits are exact
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            prod[k] = {{(ACC_W-DATA_W){x[DATA_W-1]}}, x} *
                      {{(ACC_W-COEF_W){h_q[k][COEF_W-1]}}, h_q[k]};
        end
    end

    // Output tap sum and next delay-line contents for an accepted sample
    always_comb begin
        acc = prod[0] + z_q[0];
        for (int j = 0; j < TAPS-2; j++) begin
            z_d[j] = prod[j+1] + z_q[j+1];
        end
        z_d[TAPS-2] = prod[TAPS-1];
    end

`ifdef FIR_SAT_EN
    localparam logic [ACC_W:0] RND  = (SHIFT > 0) ?
                                      ((ACC_W+1)'(1) << ((SHIFT > 0) ? SHIFT-1 : 0)) : '0;
    localparam logic [ACC_W:0] MAXV = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic [ACC_W:0] MINV = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

    logic [ACC_W:0] rnd, shv;
    logic           sat_q, sat_d;

    // Round half-up (one extra bit so the rounding add cannot overflow), shift, then clamp
    always_comb begin
        rnd   = {acc[ACC_W-1], acc} + RND;
        shv   = $signed(rnd) >>> SHIFT;
        y_d   = OUT_W'(shv);
        sat_d = 1'b0;
        if ($signed(shv) > $signed(MAXV)) begin
            y_d   = OUT_W'(MAXV);
            sat_d = 1'b1;
        end else if ($signed(shv) < $signed(MINV)) begin
            y_d   = OUT_W'(MINV);
            sat_d = 1'b1;
        end
    end

    // Saturation flag tracks the most recent result only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
        end else if (in_valid && !clear) begin
            sat_q <= sat_d;
        end
    end

    assign sat = sat_q;
`else
    // Truncating shift and wrap to OUT_W bits
    always_comb begin
        y_d = OUT_W'($signed(acc) >>> SHIFT);
    end

    assign sat = 1'b0;
`endif

    // Coefficient bank, delay line and output register; clear flushes history but keeps h
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_q         <= '{default: '0};
            z_q         <= '{default: '0};
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // Addresses >= TAPS match no entry, so such writes are dropped
            for (int k = 0; k < TAPS; k++) begin
                if (coef_we && coef_addr == AW'(k)) begin
                    h_q[k] <= coef_data;
                end
            end
            if (clear) begin
                z_q         <= '{default: '0};
                out_valid_q <= 1'b0;
            end else if (in_valid) begin
                z_q         <= z_d;
                y_q         <= y_d;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_transposed_ntap.sv
// Testbench for fir_transposed_ntap (default TAPS=8, 16-bit data/coef/out, SHIFT=0).
// Expected results come from a direct-form model that remembers the coefficients seen by each sample.
// Outputs are sampled on the falling edge, inputs driven on the falling edge.
module tb_fir_transposed_ntap;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid, coef_we;
    logic [15:0] x, coef_data;
    logic [2:0]  coef_addr;
    logic        out_valid;
    logic [15:0] y;
    logic        sat;

    always #5 clk = ~clk;

    fir_transposed_ntap dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .x         (x),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .out_valid (out_valid),
        .y         (y),
        .sat       (sat)
    );

    typedef struct packed {
        logic [15:0]      x;
        logic [7:0][15:0] h;
    } samp_t;

    samp_t            hist[$];
    logic [7:0][15:0] mh;
    logic [16:0]      exp_q[$];
    int               ncmp = 0;
    int               nfail = 0;

    // y[n] = sum_k h_k(as loaded when sample n-k arrived) * x[n-k]
    function automatic logic [16:0] model_y();
        longint acc = 0;
        for (int i = 0; i < hist.size(); i++) begin
            acc += longint'($signed(hist[i].x)) * longint'($signed(hist[i].h[i]));
        end
`ifdef FIR_SAT_EN
        if (acc > 32767) return {1'b1, 16'h7fff};
        if (acc < -32768) return {1'b1, 16'h8000};
        return {1'b0, acc[15:0]};
`else
        return {1'b0, acc[15:0]};
`endif
    endfunction

    task automatic tick(input logic v, input logic [15:0] xv, input logic cl,
                        input logic we, input logic [2:0] a, input logic [15:0] d);
        samp_t s;
        in_valid = v; x = xv; clear = cl; coef_we = we; coef_addr = a; coef_data = d;
        if (cl) begin
            hist.delete();
        end else if (v) begin
            s.x = xv;
            s.h = mh;
            hist.push_front(s);
            if (hist.size() > 8) void'(hist.pop_back());
            exp_q.push_back(model_y());
        end
        if (we) mh[a] = d;
        @(negedge clk);
    endtask

    task automatic load_h(input logic [7:0][15:0] hv);
        for (int i = 0; i < 8; i++) tick(1'b0, 16'd0, 1'b0, 1'b1, 3'(i), hv[i]);
        tick(1'b0, 16'd0, 1'b1, 1'b0, 3'd0, 16'd0);
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 0; in_valid = 0; coef_we = 0; x = 0; coef_addr = 0; coef_data = 0;
        mh = '0;
        #1 rst = 1'b0;
        @(negedge clk); @(negedge clk);
        ncmp++; if (out_valid !== 1'b0) begin nfail++; $display("FAIL reset_vld: got %b want 0", out_valid); end
        ncmp++; if (y !== 16'd0) begin nfail++; $display("FAIL reset_y: got %0d want 0", y); end
        ncmp++; if (sat !== 1'b0) begin nfail++; $display("FAIL reset_sat: got %b want 0", sat); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0][15:0] hv;
        logic [16:0] e;
        hv = '0; hv[0] = 16'd1; hv[1] = 16'd2; hv[2] = 16'd3;
        load_h(hv);
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 16'(i), 1'b0, 1'b0, 3'd0, 16'd0);
            e = exp_q.pop_front(); ncmp++;
            if (out_valid !== 1'b1 || {sat, y} !== e) begin
                nfail++; $display("FAIL basic[%0d]: got vld=%b sat=%b y=%0d want vld=1 sat=%b y=%0d",
                                  i, out_valid, sat, $signed(y), e[16], $signed(e[15:0]));
            end
        end
        tick(1'b0, 16'd99, 1'b0, 1'b0, 3'd0, 16'd0);
        ncmp++;
        if (out_valid !== 1'b0 || y !== e[15:0]) begin
            nfail++; $display("FAIL basic_idle: got vld=%b y=%0d want vld=0 y=%0d", out_valid, y, e[15:0]);
        end
    endtask

    task automatic test_impulse(input logic gaps);
        logic [7:0][15:0] hv;
        logic [16:0] e;
        logic [15:0] last;
        for (int i = 0; i < 8; i++) hv[i] = 16'(i + 1);
        load_h(hv);
        last = y;
        for (int i = 0; i < 9; i++) begin
            if (gaps) begin
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    tick(1'b0, 16'h5555, 1'b0, 1'b0, 3'd0, 16'd0);
                    ncmp++;
                    if (out_valid !== 1'b0 || y !== last) begin
                        nfail++; $display("FAIL gap_idle[%0d]: got vld=%b y=%0d want vld=0 y=%0d", i, out_valid, y, last);
                    end
                end
            end
            tick(1'b1, (i == 0) ? 16'd1 : 16'd0, 1'b0, 1'b0, 3'd0, 16'd0);
            e = exp_q.pop_front(); ncmp++; last = e[15:0];
            if (out_valid !== 1'b1 || {sat, y} !== e) begin
                nfail++; $display("FAIL impulse[%0d] gaps=%b: got vld=%b y=%0d want vld=1 y=%0d",
                                  i, gaps, out_valid, $signed(y), $signed(e[15:0]));
            end
        end
    endtask

    task automatic test_sat();
        logic [7:0][15:0] hv;
        logic [16:0] e;
        logic [15:0] xs [2];
        xs[0] = 16'h7fff; xs[1] = 16'h8000;
        hv = '0; hv[0] = 16'h7fff;
        for (int i = 0; i < 2; i++) begin
            load_h(hv);
            tick(1'b1, xs[i], 1'b0, 1'b0, 3'd0, 16'd0);
            e = exp_q.pop_front(); ncmp++;
            if (out_valid !== 1'b1 || {sat, y} !== e) begin
                nfail++; $display("FAIL sat[%0d]: got sat=%b y=%h want sat=%b y=%h", i, sat, y, e[16], e[15:0]);
            end
        end
    endtask

    task automatic test_coef_same_cycle();
        logic [7:0][15:0] hv;
        logic [16:0] e;
        hv = '0; hv[0] = 16'd1; hv[1] = 16'd2; hv[2] = 16'd3;
        load_h(hv);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 16'd1, 1'b0, (i == 0), 3'd0, 16'd5);
            e = exp_q.pop_front(); ncmp++;
            if (out_valid !== 1'b1 || {sat, y} !== e) begin
                nfail++; $display("FAIL coef_wr[%0d]: got y=%0d want y=%0d", i, $signed(y), $signed(e[15:0]));
            end
        end
    endtask

    task automatic test_clear();
        logic [7:0][15:0] hv;
        logic [16:0] e;
        hv = '0; hv[0] = 16'd1; hv[1] = 16'd2; hv[2] = 16'd3;
        load_h(hv);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 16'd4, 1'b0, 1'b0, 3'd0, 16'd0);
            e = exp_q.pop_front(); ncmp++;
            if (out_valid !== 1'b1 || {sat, y} !== e) begin
                nfail++; $display("FAIL clear_pre[%0d]: got y=%0d want y=%0d", i, $signed(y), $signed(e[15:0]));
            end
        end
        tick(1'b1, 16'd9, 1'b1, 1'b0, 3'd0, 16'd0);
        ncmp++;
        if (out_valid !== 1'b0 || y !== e[15:0]) begin
            nfail++; $display("FAIL clear_drop: got vld=%b y=%0d want vld=0 y=%0d", out_valid, y, e[15:0]);
        end
        tick(1'b1, 16'd1, 1'b0, 1'b0, 3'd0, 16'd0);
        e = exp_q.pop_front(); ncmp++;
        if (out_valid !== 1'b1 || {sat, y} !== e) begin
            nfail++; $display("FAIL clear_post: got y=%0d want y=%0d", $signed(y), $signed(e[15:0]));
        end
    endtask

    task automatic test_reset_midstream();
        logic [7:0][15:0] hv;
        logic [16:0] e;
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 16'd7, 1'b0, 1'b0, 3'd0, 16'd0);
            e = exp_q.pop_front(); ncmp++;
            if (out_valid !== 1'b1 || {sat, y} !== e) begin
                nfail++; $display("FAIL mid_pre[%0d]: got y=%0d want y=%0d", i, $signed(y), $signed(e[15:0]));
            end
        end
        #2 rst = 1'b0;
        mh = '0; hist.delete();
        #1;
        ncmp++;
        if (out_valid !== 1'b0 || y !== 16'd0) begin
            nfail++; $display("FAIL mid_rst: got vld=%b y=%0d want vld=0 y=0", out_valid, y);
        end
        in_valid = 0; clear = 0; coef_we = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tick(1'b1, 16'd5, 1'b0, 1'b0, 3'd0, 16'd0);
        e = exp_q.pop_front(); ncmp++;
        if (out_valid !== 1'b1 || {sat, y} !== e) begin
            nfail++; $display("FAIL mid_zero_h: got y=%0d want y=%0d", $signed(y), $signed(e[15:0]));
        end
        hv = '0; hv[0] = 16'd1; hv[1] = 16'd2; hv[2] = 16'd3;
        load_h(hv);
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 16'd1, 1'b0, 1'b0, 3'd0, 16'd0);
            e = exp_q.pop_front(); ncmp++;
            if (out_valid !== 1'b1 || {sat, y} !== e) begin
                nfail++; $display("FAIL mid_post[%0d]: got y=%0d want y=%0d", i, $signed(y), $signed(e[15:0]));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_impulse(1'b0);
        test_impulse(1'b1);
        test_sat();
        test_coef_same_cycle();
        test_clear();
        test_reset_midstream();
        ncmp++;
        if (exp_q.size() != 0) begin
            nfail++; $display("FAIL leftover: got %0d pending results want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
